// File: rtl/pio_multi_if.sv
// rtl/pio_multi_if.sv - Avalon-MM slave bus bundle for the pio_multi peripheral
interface pio_multi_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/pio_multi.sv
// rtl/pio_multi.sv - configurable-width parallel I/O with direction, set/clear,
// synchronised inputs, sticky edge capture and a maskable level interrupt
module pio_multi #(
  parameter int unsigned      WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '1,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  pio_multi_if.slave       bus,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_export,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_CAP    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int unsigned     WARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned     CNT_W       = $clog2(WARM_CYCLES + 1);
  localparam logic [CNT_W-1:0] WARM_DONE  = CNT_W'(WARM_CYCLES);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] hist_q;
  logic [CNT_W-1:0] warm_q, warm_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] raw_edges;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] data_view;
  logic             unused_wdata;

  // Writedata bits above WIDTH carry no meaning for this block.
  assign unused_wdata = ^bus.avs_writedata;

  assign wdata   = bus.avs_writedata[WIDTH-1:0];
  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    raw_edges = '0;
    if (EDGE_TYPE == 0) begin
      raw_edges = sync_in & ~hist_q;
    end else if (EDGE_TYPE == 1) begin
      raw_edges = ~sync_in & hist_q;
    end else begin
      raw_edges = sync_in ^ hist_q;
    end
    // Synchroniser reset zeros would otherwise look like edges on high pins.
    edges  = (warm_q == WARM_DONE) ? raw_edges : '0;
    warm_d = (warm_q == WARM_DONE) ? warm_q : warm_q + 1'b1;
  end

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    cap_clr = '0;
    if (bus.avs_write) begin
      case (bus.avs_address)
        ADDR_DATA:   out_d   = wdata;
        ADDR_DIR:    dir_d   = wdata;
        ADDR_MASK:   mask_d  = wdata;
        ADDR_CAP:    cap_clr = wdata;
        ADDR_OUTSET: out_d   = out_q | wdata;
        ADDR_OUTCLR: out_d   = out_q & ~wdata;
        default:     ;
      endcase
    end
    // A fresh edge overrides a simultaneous write-1-to-clear.
    cap_d = (cap_q & ~cap_clr) | edges;
    irq_d = |(cap_q & mask_q);
  end

  always_comb begin
    data_view = (out_q & dir_q) | (sync_in & ~dir_q);
    rdata_d   = '0;
    if (bus.avs_read) begin
      case (bus.avs_address)
        ADDR_DATA: rdata_d[WIDTH-1:0] = data_view;
        ADDR_DIR:  rdata_d[WIDTH-1:0] = dir_q;
        ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
        ADDR_CAP:  rdata_d[WIDTH-1:0] = cap_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q    <= RESET_VALUE;
      dir_q    <= RESET_DIR;
      mask_q   <= '0;
      cap_q    <= '0;
      sync_q   <= '0;
      hist_q   <= '0;
      warm_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      dir_q    <= dir_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pio_in};
      hist_q   <= sync_in;
      warm_q   <= warm_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.avs_read;
      irq_q    <= irq_d;
    end
  end

  assign pio_export            = out_q;
  assign pio_oe                = dir_q;
  assign irq                   = irq_q;
  assign bus.avs_readdata      = rdata_q;
  assign bus.avs_readdatavalid = rvalid_q;

endmodule

// File: tb/tb_pio_multi.sv
// tb/tb_pio_multi.sv - scoreboard bench for pio_multi with a behavioural reference model
module tb_pio_multi;
  localparam int W  = 10;
  localparam int S  = 2;
  localparam int ET = 0;
  localparam logic [W-1:0] RV = 10'h155;
  localparam logic [W-1:0] RD = 10'h3FF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pio_in = '0;
  logic [W-1:0] pio_export;
  logic [W-1:0] pio_oe;
  logic         irq;

  pio_multi_if bus();

  pio_multi #(
    .WIDTH(W), .RESET_VALUE(RV), .RESET_DIR(RD), .EDGE_TYPE(ET), .SYNC_STAGES(S)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .bus(bus),
    .pio_in(pio_in),
    .pio_export(pio_export),
    .pio_oe(pio_oe),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];
  time         exp_t[$];
  logic [31:0] mon_e;
  time         mon_t;

  logic [W-1:0] m_out, m_dir, m_mask, m_cap;
  logic         m_irq;
  int           m_age;
  logic [W-1:0] pin_log[$];
  logic [W-1:0] pin_v = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out  = RV;
    m_dir  = RD;
    m_mask = '0;
    m_cap  = '0;
    m_irq  = 1'b0;
    m_age  = 0;
    pin_log.delete();
    repeat (S + 1) pin_log.push_back('0);
    exp_q.delete();
    exp_t.delete();
  endtask

  // One clock edge of the register map: pins are seen S edges late, edges compare
  // consecutive delayed samples, reads see pre-edge state.
  task automatic model_step(input logic rd, input logic wr, input logic [2:0] a,
                            input logic [31:0] wd, input logic [W-1:0] pin,
                            input bit fixed, input logic [31:0] fixv);
    logic [W-1:0] syn, his, ev, w;
    logic [31:0]  r;
    syn = pin_log[pin_log.size() - S];
    his = pin_log[pin_log.size() - S - 1];
    if (rd) begin
      r = '0;
      case (a)
        3'd0: r[W-1:0] = (m_out & m_dir) | (syn & ~m_dir);
        3'd1: r[W-1:0] = m_dir;
        3'd2: r[W-1:0] = m_mask;
        3'd3: r[W-1:0] = m_cap;
        default: r = '0;
      endcase
      exp_q.push_back(fixed ? fixv : r);
      exp_t.push_back($time);
    end
    if (ET == 0)      ev = syn & ~his;
    else if (ET == 1) ev = ~syn & his;
    else              ev = syn ^ his;
    if (m_age < S + 1) ev = '0;
    m_irq = |(m_cap & m_mask);
    w = wd[W-1:0];
    if (wr) begin
      case (a)
        3'd0: m_out = w;
        3'd1: m_dir = w;
        3'd2: m_mask = w;
        3'd3: m_cap = m_cap & ~w;
        3'd4: m_out = m_out | w;
        3'd5: m_out = m_out & ~w;
        default: ;
      endcase
    end
    m_cap = m_cap | ev;
    m_age++;
    pin_log.push_back(pin);
    if (pin_log.size() > 16) void'(pin_log.pop_front());
  endtask

  task automatic do_cycle(input logic rd, input logic wr, input logic [2:0] a,
                          input logic [31:0] wd, input bit fixed = 1'b0,
                          input logic [31:0] fixv = '0);
    bus.avs_read      = rd;
    bus.avs_write     = wr;
    bus.avs_address   = a;
    bus.avs_writedata = wd;
    pio_in            = pin_v;
    @(posedge clk);
    model_step(rd, wr, a, wd, pin_v, fixed, fixv);
    #1;
    check("pio_export", 32'(pio_export), 32'(m_out));
    check("pio_oe", 32'(pio_oe), 32'(m_dir));
    check("irq", 32'(irq), 32'(m_irq));
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.avs_readdatavalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL readdatavalid: got unexpected pulse data %h expected none", bus.avs_readdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t.pop_front();
        check("readdata", bus.avs_readdata, mon_e);
        check("read_latency", 32'($time - mon_t), 32'd5);
      end
    end
  end

  int n;

  initial begin
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_address = '0;
    bus.avs_writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_export", 32'(pio_export), 32'h155);
    check("reset_oe", 32'(pio_oe), 32'h3FF);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rvalid", 32'(bus.avs_readdatavalid), 32'd0);
    rst_n = 1'b1;
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 32'd0);
    idle(S + 3);

    do_cycle(1'b0, 1'b1, 3'd0, 32'h0F0);
    check("set_clr_data", 32'(pio_export), 32'h0F0);
    do_cycle(1'b0, 1'b1, 3'd4, 32'h003);
    check("set_clr_outset", 32'(pio_export), 32'h0F3);
    do_cycle(1'b0, 1'b1, 3'd5, 32'h030);
    check("set_clr_outclr", 32'(pio_export), 32'h0C3);
    do_cycle(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 32'h0C3);

    do_cycle(1'b0, 1'b1, 3'd1, 32'h00F);
    do_cycle(1'b0, 1'b1, 3'd0, 32'h3FF);
    pin_v = 10'h2A0;
    idle(S);
    do_cycle(1'b1, 1'b0, 3'd0, 32'd0, 1'b1, 32'h2AF);
    do_cycle(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b1, 3'd1, 32'h0, 1'b1, 32'h3FF);
    do_cycle(1'b1, 1'b0, 3'd1, 32'd0, 1'b1, 32'h0);

    do_cycle(1'b1, 1'b1, 3'd6, $urandom, 1'b1, 32'h0);
    do_cycle(1'b1, 1'b1, 3'd7, $urandom, 1'b1, 32'h0);

    pin_v = '0;
    idle(S + 2);
    do_cycle(1'b0, 1'b1, 3'd3, 32'h3FF);
    do_cycle(1'b0, 1'b1, 3'd2, 32'h001);
    pin_v = 10'h001;
    do_cycle(1'b0, 1'b0, 3'd0, 32'd0);
    n = 1;
    while (!irq && n < 20) begin
      idle(1);
      n++;
    end
    check("irq_latency", 32'(n), 32'(S + 2));
    pin_v = 10'h003;
    idle(1);
    pin_v = 10'h001;
    idle(S + 2);
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 32'h003);
    do_cycle(1'b0, 1'b1, 3'd3, 32'h001);
    check("irq_before_drop", 32'(irq), 32'd1);
    idle(1);
    check("irq_dropped", 32'(irq), 32'd0);
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 32'h002);

    pin_v = '0;
    idle(S + 2);
    pin_v = 10'h001;
    idle(S + 2);
    pin_v = '0;
    idle(S + 2);
    pin_v = 10'h001;
    idle(S);
    do_cycle(1'b0, 1'b1, 3'd3, 32'h001);
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 32'h003);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) pin_v = pin_v ^ W'($urandom);
      do_cycle(1'($urandom), ($urandom_range(2) == 0), 3'($urandom), $urandom);
    end

    pin_v = 10'h3FF;
    idle(3);
    do_cycle(1'b1, 1'b0, 3'd0, 32'd0);
    check("pending_rvalid", 32'(bus.avs_readdatavalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rvalid", 32'(bus.avs_readdatavalid), 32'd0);
    check("async_rdata", bus.avs_readdata, 32'd0);
    check("async_export", 32'(pio_export), 32'h155);
    check("async_oe", 32'(pio_oe), 32'h3FF);
    check("async_irq", 32'(irq), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(S + 4);
    do_cycle(1'b1, 1'b0, 3'd3, 32'd0, 1'b1, 32'h0);
    idle(2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end
endmodule
